// File: rtl/mem_rr_arb_pkg.sv
// Shared definitions for the memory bus arbiter and its round-robin picker.
// Holds the state encoding, index-width helper and one-hot helper.
package mem_rr_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    DONE   = ST_DONE
  } state_t;

  // Upper bound on clients so the one-hot helper can return a fixed width.
  localparam int MAX_CLIENTS = 32;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_CLIENTS-1:0] onehot_from_idx(input int idx);
    return {{(MAX_CLIENTS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mem_rr_arb_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
// Shared with the I/O arbiters, so it carries no arbiter state of its own.
module rr_pick
  import mem_rr_arb_pkg::*;
#(
  parameter int CLIENT_CNT = 2,
  parameter int IDX_W      = idx_width(CLIENT_CNT)
) (
  input  logic [CLIENT_CNT-1:0] requests,
  input  logic [IDX_W-1:0]      last,
  output logic [IDX_W-1:0]      idx,
  output logic                  valid
);

  logic [IDX_W-1:0] cand;

  // Scan last+1, last+2, ... and stop at the first hit; last itself comes last.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= CLIENT_CNT; k++) begin
      cand = IDX_W'((int'(last) + k) % CLIENT_CNT);
      if (!valid && requests[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arb.sv
// Round-robin arbiter/sequencer for the shared memory bus: one client at a
// time, fixed wait cycles per access, 4-phase request/ready handshake.
module mem_rr_arb
  import mem_rr_arb_pkg::*;
#(
  parameter int CLIENT_CNT  = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CLIENT_CNT-1:0]        requests,
  input  logic [CLIENT_CNT*ADDR_W-1:0] addrs,
  input  logic [CLIENT_CNT-1:0]        wes,
  input  logic [CLIENT_CNT*DATA_W-1:0] data_outs,
  output logic [CLIENT_CNT-1:0]        readies,
  output logic [DATA_W-1:0]            rdata,
  output logic [CLIENT_CNT-1:0]        grant,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic                         mem_we,
  input  logic [DATA_W-1:0]            mem_rdata
);

  localparam int IDX_W = idx_width(CLIENT_CNT);
  localparam int CNT_W = idx_width(WAIT_CYCLES);

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("mem_rr_arb: WAIT_CYCLES must be at least 1");
  end
  if (CLIENT_CNT < 1 || CLIENT_CNT > MAX_CLIENTS) begin : g_bad_clients
    $error("mem_rr_arb: CLIENT_CNT out of range");
  end

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic [IDX_W-1:0]      last, last_next;
  logic [IDX_W-1:0]      gidx, gidx_next;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_valid;
  logic [CLIENT_CNT-1:0] readies_next, grant_next;
  logic [ADDR_W-1:0]     addr_next;
  logic [DATA_W-1:0]     wdata_next, rdata_next;
  logic                  we_next;

  logic [ADDR_W-1:0] addr_arr [CLIENT_CNT];
  logic [DATA_W-1:0] data_arr [CLIENT_CNT];

  for (genvar i = 0; i < CLIENT_CNT; i++) begin : g_unpack
    assign addr_arr[i] = addrs[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = data_outs[i*DATA_W +: DATA_W];
  end

  rr_pick #(
    .CLIENT_CNT (CLIENT_CNT),
    .IDX_W      (IDX_W)
  ) u_pick (
    .requests (requests),
    .last     (last),
    .idx      (pick_idx),
    .valid    (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last      <= IDX_W'(CLIENT_CNT - 1);
      gidx      <= '0;
      readies   <= '0;
      grant     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rdata     <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      last      <= last_next;
      gidx      <= gidx_next;
      readies   <= readies_next;
      grant     <= grant_next;
      mem_addr  <= addr_next;
      mem_wdata <= wdata_next;
      mem_we    <= we_next;
      rdata     <= rdata_next;
    end
  end

  // Bus outputs are only loaded in IDLE, so the holder cannot disturb an
  // access in flight; mem_we itself tells ACCESS whether it is a read.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    last_next    = last;
    gidx_next    = gidx;
    readies_next = readies;
    grant_next   = grant;
    addr_next    = mem_addr;
    wdata_next   = mem_wdata;
    we_next      = mem_we;
    rdata_next   = rdata;

    case (state)
      IDLE: begin
        if (pick_valid) begin
          gidx_next  = pick_idx;
          grant_next = CLIENT_CNT'(onehot_from_idx(int'(pick_idx)));
          addr_next  = addr_arr[pick_idx];
          wdata_next = data_arr[pick_idx];
          we_next    = wes[pick_idx];
          cnt_next   = CNT_W'(WAIT_CYCLES - 1);
          state_next = ACCESS;
        end else begin
          we_next = 1'b0;
        end
      end
      ACCESS: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          if (!mem_we) begin
            rdata_next = mem_rdata;
          end
          we_next      = 1'b0;
          readies_next = CLIENT_CNT'(onehot_from_idx(int'(gidx)));
          state_next   = DONE;
        end
      end
      DONE: begin
        if (!requests[gidx]) begin
          readies_next = '0;
          grant_next   = '0;
          last_next    = gidx;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_rr_arb.sv
// Bench for mem_rr_arb: a WAIT_CYCLES=1 and a WAIT_CYCLES=3 instance, driven by
// a vector table, directed multi-cycle sequences and random traffic vs a model.
module tb_mem_rr_arb;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0]  req   [2];
  logic [N-1:0]  wes   [2];
  logic [N-1:0]  rdy   [2];
  logic [N-1:0]  gnt   [2];
  logic [7:0]    ca    [2][2];
  logic [7:0]    cd    [2][2];
  logic [15:0]   addrs [2];
  logic [15:0]   wds   [2];
  logic [7:0]    rdata [2];
  logic [7:0]    mwdata[2];
  logic [7:0]    mrdata[2];
  logic [7:0]    maddr [2];
  logic          mwe   [2];

  int total = 0;
  int bad   = 0;

  // Model of each arbiter in terms of "who holds the bus and for how long".
  int         m_hold[2] = '{-1, -1};
  int         m_age [2] = '{0, 0};
  int         m_last[2] = '{N-1, N-1};
  logic [7:0] m_addr[2] = '{8'h00, 8'h00};
  logic [7:0] m_wd  [2] = '{8'h00, 8'h00};
  logic [7:0] m_rd  [2] = '{8'h00, 8'h00};
  logic       m_wr  [2] = '{1'b0, 1'b0};

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [1:0] eg;
    logic [1:0] er;
    logic       ewe;
    logic [7:0] ea;
    logic [7:0] ewd;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] memf(input logic [7:0] a);
    if (a == 8'h20) return 8'h3C;
    return (a * 8'd7) ^ 8'h5A;
  endfunction

  function automatic int wv(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  assign addrs[0]  = {ca[0][1], ca[0][0]};
  assign addrs[1]  = {ca[1][1], ca[1][0]};
  assign wds[0]    = {cd[0][1], cd[0][0]};
  assign wds[1]    = {cd[1][1], cd[1][0]};
  assign mrdata[0] = memf(maddr[0]);
  assign mrdata[1] = memf(maddr[1]);

  mem_rr_arb #(.CLIENT_CNT(N), .ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst), .requests(req[0]), .addrs(addrs[0]), .wes(wes[0]),
    .data_outs(wds[0]), .readies(rdy[0]), .rdata(rdata[0]), .grant(gnt[0]),
    .mem_addr(maddr[0]), .mem_wdata(mwdata[0]), .mem_we(mwe[0]), .mem_rdata(mrdata[0])
  );

  mem_rr_arb #(.CLIENT_CNT(N), .ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst), .requests(req[1]), .addrs(addrs[1]), .wes(wes[1]),
    .data_outs(wds[1]), .readies(rdy[1]), .rdata(rdata[1]), .grant(gnt[1]),
    .mem_addr(maddr[1]), .mem_wdata(mwdata[1]), .mem_we(mwe[1]), .mem_rdata(mrdata[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model with the inputs that the coming edge will sample.
  task automatic modelStep();
    int c;
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        m_hold[d] = -1;
        m_age[d]  = 0;
        m_last[d] = N - 1;
        m_addr[d] = 8'h00;
        m_wd[d]   = 8'h00;
        m_rd[d]   = 8'h00;
        m_wr[d]   = 1'b0;
      end else if (m_hold[d] < 0) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last[d] + k) % N;
          if (m_hold[d] < 0 && req[d][c]) begin
            m_hold[d] = c;
            m_age[d]  = 0;
            m_addr[d] = ca[d][c];
            m_wd[d]   = cd[d][c];
            m_wr[d]   = wes[d][c];
          end
        end
      end else begin
        m_age[d]++;
        if (m_age[d] == wv(d)) begin
          if (!m_wr[d]) m_rd[d] = memf(m_addr[d]);
        end else if (m_age[d] > wv(d) && !req[d][m_hold[d]]) begin
          m_last[d] = m_hold[d];
          m_hold[d] = -1;
        end
      end
    end
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic compareModel(input int d);
    logic [1:0] eg, er;
    logic       ewe;
    eg  = (m_hold[d] >= 0) ? (2'b01 << m_hold[d]) : 2'b00;
    er  = (m_hold[d] >= 0 && m_age[d] >= wv(d)) ? eg : 2'b00;
    ewe = (m_hold[d] >= 0) && m_wr[d] && (m_age[d] < wv(d));
    checkOutput($sformatf("rnd_grant_d%0d", d), gnt[d], eg);
    checkOutput($sformatf("rnd_ready_d%0d", d), rdy[d], er);
    checkOutput($sformatf("rnd_we_d%0d", d), mwe[d], ewe);
    checkOutput($sformatf("rnd_addr_d%0d", d), maddr[d], m_addr[d]);
    checkOutput($sformatf("rnd_wdata_d%0d", d), mwdata[d], m_wd[d]);
    checkOutput($sformatf("rnd_rdata_d%0d", d), rdata[d], m_rd[d]);
  endtask

  task automatic expect3(input string name, input logic [1:0] eg, input logic [1:0] er,
                         input logic ewe, input logic [7:0] ea);
    checkOutput({name, "_grant"}, gnt[1], eg);
    checkOutput({name, "_ready"}, rdy[1], er);
    checkOutput({name, "_we"}, mwe[1], ewe);
    checkOutput({name, "_addr"}, maddr[1], ea);
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic [1:0] we,
                              input logic [7:0] a0, input logic [7:0] a1, input logic [1:0] eg,
                              input logic [1:0] er, input logic ewe, input logic [7:0] ea,
                              input logic [7:0] ewd);
    vec_t v;
    v.rst = r; v.req = rq; v.we = we; v.a0 = a0; v.a1 = a1;
    v.eg = eg; v.er = er; v.ewe = ewe; v.ea = ea; v.ewd = ewd;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst      = v.rst;
    req[0]   = v.req;
    wes[0]   = v.we;
    ca[0][0] = v.a0;
    ca[0][1] = v.a1;
    cd[0][0] = 8'hA5;
    cd[0][1] = 8'hA5;
  endtask

  task automatic randClient(input int d);
    for (int i = 0; i < N; i++) begin
      if (req[d][i]) begin
        if (rdy[d][i]) begin
          if ($urandom_range(3) != 0) req[d][i] = 1'b0;
        end else if ($urandom_range(15) == 0) begin
          req[d][i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          ca[d][i]  = 8'($urandom);
          cd[d][i]  = 8'($urandom);
          wes[d][i] = 1'($urandom);
        end
      end else if ($urandom_range(1) == 0) begin
        req[d][i] = 1'b1;
        ca[d][i]  = 8'($urandom);
        cd[d][i]  = 8'($urandom);
        wes[d][i] = 1'($urandom);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req[d] = '0;
      wes[d] = '0;
      for (int i = 0; i < N; i++) begin
        ca[d][i] = 8'h00;
        cd[d][i] = 8'h00;
      end
    end

    // W=1 instance: reset during a write, single write, fairness after reset.
    tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 2'b01, 2'b01, 8'h10, 8'h20, 2'b01, 2'b00, 1, 8'h10, 8'hA5));
    tbl.push_back(mk(0, 2'b01, 2'b01, 8'h10, 8'h20, 2'b00, 2'b00, 0, 8'h00, 8'h00));
    tbl.push_back(mk(0, 2'b01, 2'b01, 8'h10, 8'h20, 2'b00, 2'b00, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 2'b00, 2'b00, 8'h10, 8'h20, 2'b00, 2'b00, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 2'b00, 2'b00, 8'h10, 8'h20, 2'b00, 2'b00, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 2'b01, 2'b01, 8'h10, 8'h20, 2'b01, 2'b00, 1, 8'h10, 8'hA5));
    tbl.push_back(mk(1, 2'b01, 2'b01, 8'h10, 8'h20, 2'b01, 2'b01, 0, 8'h10, 8'hA5));
    tbl.push_back(mk(1, 2'b01, 2'b01, 8'h10, 8'h20, 2'b01, 2'b01, 0, 8'h10, 8'hA5));
    tbl.push_back(mk(1, 2'b00, 2'b01, 8'h10, 8'h20, 2'b00, 2'b00, 0, 8'h10, 8'hA5));
    tbl.push_back(mk(0, 2'b00, 2'b00, 8'h11, 8'h21, 2'b00, 2'b00, 0, 8'h00, 8'h00));
    tbl.push_back(mk(1, 2'b11, 2'b00, 8'h11, 8'h21, 2'b01, 2'b00, 0, 8'h11, 8'hA5));
    tbl.push_back(mk(1, 2'b11, 2'b00, 8'h11, 8'h21, 2'b01, 2'b01, 0, 8'h11, 8'hA5));
    tbl.push_back(mk(1, 2'b10, 2'b00, 8'h11, 8'h21, 2'b00, 2'b00, 0, 8'h11, 8'hA5));
    tbl.push_back(mk(1, 2'b11, 2'b00, 8'h11, 8'h21, 2'b10, 2'b00, 0, 8'h21, 8'hA5));
    tbl.push_back(mk(1, 2'b11, 2'b00, 8'h11, 8'h21, 2'b10, 2'b10, 0, 8'h21, 8'hA5));
    tbl.push_back(mk(1, 2'b01, 2'b00, 8'h11, 8'h21, 2'b00, 2'b00, 0, 8'h21, 8'hA5));
    tbl.push_back(mk(1, 2'b11, 2'b00, 8'h11, 8'h21, 2'b01, 2'b00, 0, 8'h11, 8'hA5));
    tbl.push_back(mk(1, 2'b11, 2'b00, 8'h11, 8'h21, 2'b01, 2'b01, 0, 8'h11, 8'hA5));
    tbl.push_back(mk(1, 2'b10, 2'b00, 8'h11, 8'h21, 2'b00, 2'b00, 0, 8'h11, 8'hA5));
    tbl.push_back(mk(1, 2'b11, 2'b00, 8'h11, 8'h21, 2'b10, 2'b00, 0, 8'h21, 8'hA5));
    tbl.push_back(mk(1, 2'b11, 2'b00, 8'h11, 8'h21, 2'b10, 2'b10, 0, 8'h21, 8'hA5));
    tbl.push_back(mk(1, 2'b00, 2'b00, 8'h11, 8'h21, 2'b00, 2'b00, 0, 8'h21, 8'hA5));

    for (int r = 0; r < tbl.size(); r++) begin
      applyStimulus(tbl[r]);
      tick();
      checkOutput($sformatf("vec%0d_grant", r), gnt[0], tbl[r].eg);
      checkOutput($sformatf("vec%0d_ready", r), rdy[0], tbl[r].er);
      checkOutput($sformatf("vec%0d_we", r), mwe[0], tbl[r].ewe);
      checkOutput($sformatf("vec%0d_addr", r), maddr[0], tbl[r].ea);
      checkOutput($sformatf("vec%0d_wdata", r), mwdata[0], tbl[r].ewd);
    end
    req[0] = '0;

    // W=3 read by client 1.
    req[1] = 2'b10; wes[1] = 2'b00; ca[1][1] = 8'h20;
    tick(); expect3("rd_grant", 2'b10, 2'b00, 0, 8'h20);
    tick(); expect3("rd_wait1", 2'b10, 2'b00, 0, 8'h20);
    tick(); expect3("rd_wait2", 2'b10, 2'b00, 0, 8'h20);
    tick(); expect3("rd_ready", 2'b10, 2'b10, 0, 8'h20);
    checkOutput("rd_data", rdata[1], 8'h3C);
    req[1] = 2'b00;
    tick(); expect3("rd_release", 2'b00, 2'b00, 0, 8'h20);

    // Late request from client 1 while client 0 writes.
    req[1] = 2'b01; wes[1] = 2'b01; ca[1][0] = 8'h30; ca[1][1] = 8'h40; cd[1][0] = 8'h77;
    tick(); expect3("late_grant", 2'b01, 2'b00, 1, 8'h30);
    checkOutput("late_wdata", mwdata[1], 8'h77);
    req[1] = 2'b11; ca[1][0] = 8'h31; wes[1] = 2'b00;
    tick(); expect3("late_wait1", 2'b01, 2'b00, 1, 8'h30);
    tick(); expect3("late_wait2", 2'b01, 2'b00, 1, 8'h30);
    tick(); expect3("late_done", 2'b01, 2'b01, 0, 8'h30);
    checkOutput("late_rdata_kept", rdata[1], 8'h3C);
    req[1] = 2'b10;
    tick(); expect3("late_release", 2'b00, 2'b00, 0, 8'h30);
    tick(); expect3("late_next", 2'b10, 2'b00, 0, 8'h40);
    tick(); expect3("late_next_w1", 2'b10, 2'b00, 0, 8'h40);
    tick(); expect3("late_next_w2", 2'b10, 2'b00, 0, 8'h40);
    tick(); expect3("late_next_rdy", 2'b10, 2'b10, 0, 8'h40);
    checkOutput("late_next_rdata", rdata[1], memf(8'h40));
    req[1] = 2'b00;
    tick(); expect3("late_next_rel", 2'b00, 2'b00, 0, 8'h40);

    // Client 0 abandons a write mid-access; the write still runs its course.
    req[1] = 2'b01; wes[1] = 2'b01; ca[1][0] = 8'h55; cd[1][0] = 8'h99;
    tick(); expect3("abort_grant", 2'b01, 2'b00, 1, 8'h55);
    req[1] = 2'b00;
    tick(); expect3("abort_w1", 2'b01, 2'b00, 1, 8'h55);
    tick(); expect3("abort_w2", 2'b01, 2'b00, 1, 8'h55);
    tick(); expect3("abort_pulse", 2'b01, 2'b01, 0, 8'h55);
    tick(); expect3("abort_release", 2'b00, 2'b00, 0, 8'h55);
    tick(); expect3("abort_idle", 2'b00, 2'b00, 0, 8'h55);
    checkOutput("abort_rdata_kept", rdata[1], memf(8'h40));

    // Random traffic on both instances against the model.
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      randClient(0);
      randClient(1);
      tick();
      compareModel(0);
      compareModel(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
